// File: rtl/rdma_rc_qp_fsm.sv
// Connection-state controller for one RDMA RC queue pair: RESET/INIT/RTR/RTS/ERROR
// sequencing with local/remote QPN latching and data-path readiness decode.
module rdma_rc_qp_fsm #(
  parameter int QPN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [QPN_WIDTH-1:0] local_qpn,
  input  logic [QPN_WIDTH-1:0] remote_qpn,
  input  logic                 cfg_valid,
  input  logic                 cmd_connect,
  input  logic                 cmd_disconnect,
  output logic [2:0]           qp_state,
  output logic                 qp_ready
);

  typedef enum logic [2:0] {
    ST_RESET = 3'b000,
    ST_INIT  = 3'b001,
    ST_RTR   = 3'b010,
    ST_RTS   = 3'b011,
    ST_ERROR = 3'b111
  } qp_state_e;

  localparam logic [QPN_WIDTH-1:0] QPN_ZERO = {QPN_WIDTH{1'b0}};

  qp_state_e            state_r;
  qp_state_e            state_s;
  logic [QPN_WIDTH-1:0] local_qpn_r;
  logic [QPN_WIDTH-1:0] local_qpn_s;
  logic [QPN_WIDTH-1:0] remote_qpn_r;
  logic [QPN_WIDTH-1:0] remote_qpn_s;

  function automatic logic qpn_valid(input logic [QPN_WIDTH-1:0] qpn);
    return (qpn != QPN_ZERO);
  endfunction

  // State and latched QPN registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_RESET;
      local_qpn_r  <= QPN_ZERO;
      remote_qpn_r <= QPN_ZERO;
    end else begin
      state_r      <= state_s;
      local_qpn_r  <= local_qpn_s;
      remote_qpn_r <= remote_qpn_s;
    end
  end

  // Next-state logic; disconnect outranks connect, which outranks configure
  always_comb begin
    state_s      = state_r;
    local_qpn_s  = local_qpn_r;
    remote_qpn_s = remote_qpn_r;
    if (cmd_disconnect) begin
      state_s      = ST_RESET;
      local_qpn_s  = QPN_ZERO;
      remote_qpn_s = QPN_ZERO;
    end else begin
      case (state_r)
        ST_RESET: begin
          if (cmd_connect) begin
            state_s = ST_RESET;
          end else if (cfg_valid) begin
            if (qpn_valid(local_qpn)) begin
              state_s     = ST_INIT;
              local_qpn_s = local_qpn;
            end else begin
              state_s = ST_ERROR;
            end
          end else begin
            state_s = ST_RESET;
          end
        end
        ST_INIT: begin
          if (cmd_connect) begin
            if (qpn_valid(remote_qpn)) begin
              state_s      = ST_RTR;
              remote_qpn_s = remote_qpn;
            end else begin
              state_s = ST_ERROR;
            end
          end else begin
            state_s = ST_INIT;
          end
        end
        ST_RTR: begin
          if (cmd_connect) begin
            state_s = ST_RTS;
          end else begin
            state_s = ST_RTR;
          end
        end
        ST_RTS:   state_s = ST_RTS;
        ST_ERROR: state_s = ST_ERROR;
        // Corrupted encodings are trapped in ERROR until a disconnect
        default:  state_s = ST_ERROR;
      endcase
    end
  end

  assign qp_state = state_r;
  assign qp_ready = (state_r == ST_INIT) || (state_r == ST_RTR) || (state_r == ST_RTS);

endmodule

// File: tb/tb_rdma_rc_qp_fsm.sv
// Self-checking bench for rdma_rc_qp_fsm: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a phase/error-flag model.
module tb_rdma_rc_qp_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] local_qpn;
  logic [15:0] remote_qpn;
  logic        cfg_valid;
  logic        cmd_connect;
  logic        cmd_disconnect;
  logic [2:0]  qp_state;
  logic        qp_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: connection phase 0..3 (RESET..RTS) plus a sticky error flag
  int m_phase = 0;
  bit m_err   = 1'b0;

  always #5 clk = ~clk;

  rdma_rc_qp_fsm #(.QPN_WIDTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .local_qpn      (local_qpn),
    .remote_qpn     (remote_qpn),
    .cfg_valid      (cfg_valid),
    .cmd_connect    (cmd_connect),
    .cmd_disconnect (cmd_disconnect),
    .qp_state       (qp_state),
    .qp_ready       (qp_ready)
  );

  typedef struct {
    string       name;
    logic        cfg;
    logic        conn;
    logic        disc;
    logic [15:0] lq;
    logic [15:0] rq;
    logic [2:0]  exp_state;
    logic        exp_ready;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic n, input logic d,
                            input logic [15:0] lq, input logic [15:0] rq);
    if (d) begin
      model_reset();
    end else if (m_err) begin
      // only a disconnect leaves the error condition
    end else if (n) begin
      if (m_phase == 1) begin
        if (rq == 16'd0) m_err = 1'b1;
        else m_phase = 2;
      end else if (m_phase == 2) begin
        m_phase = 3;
      end
    end else if (c && m_phase == 0) begin
      if (lq == 16'd0) m_err = 1'b1;
      else m_phase = 1;
    end
  endtask

  function automatic logic [2:0] model_state();
    return m_err ? 3'd7 : 3'(m_phase);
  endfunction

  function automatic logic model_ready();
    return !m_err && (m_phase != 0);
  endfunction

  // Drive inputs for one cycle, then land 1 time unit after the rising edge
  task automatic cycle(input logic c, input logic n, input logic d,
                       input logic [15:0] lq, input logic [15:0] rq);
    cfg_valid      = c;
    cmd_connect    = n;
    cmd_disconnect = d;
    local_qpn      = lq;
    remote_qpn     = rq;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, local_qpn, remote_qpn);
  endtask

  task automatic expect_st(input string name, input logic [2:0] st, input logic rdy);
    check({name, "_state"}, 32'(qp_state), 32'(st));
    check({name, "_ready"}, 32'(qp_ready), 32'(rdy));
  endtask

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0; cmd_connect = 1'b0; cmd_disconnect = 1'b0;
    local_qpn = 16'd0; remote_qpn = 16'd0;

    // Reset hold for two edges
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      expect_st("reset_hold", 3'b000, 1'b0);
    end
    rst_n = 1'b1;
    idle(1);
    expect_st("post_reset", 3'b000, 1'b0);

    vecs.push_back('{"bringup_cfg",   1, 0, 0, 16'h1234, 16'h0000, 3'b001, 1});
    vecs.push_back('{"bringup_conn1", 0, 1, 0, 16'h1234, 16'h5678, 3'b010, 1});
    vecs.push_back('{"bringup_conn2", 0, 1, 0, 16'h1234, 16'h5678, 3'b011, 1});
    vecs.push_back('{"cfg_in_rts",    1, 0, 0, 16'h4321, 16'h5678, 3'b011, 1});
    vecs.push_back('{"rqpn_chg_rts",  0, 0, 0, 16'h4321, 16'h9999, 3'b011, 1});
    vecs.push_back('{"conn_in_rts",   0, 1, 0, 16'h4321, 16'h9999, 3'b011, 1});
    vecs.push_back('{"disc_rts",      0, 0, 1, 16'h4321, 16'h9999, 3'b000, 0});
    vecs.push_back('{"conn_in_reset", 0, 1, 0, 16'h4321, 16'h9999, 3'b000, 0});
    vecs.push_back('{"cfg_zero",      1, 0, 0, 16'h0000, 16'h9999, 3'b111, 0});
    vecs.push_back('{"err_conn",      0, 1, 0, 16'h0000, 16'h9999, 3'b111, 0});
    vecs.push_back('{"err_cfg",       1, 0, 0, 16'h0005, 16'h9999, 3'b111, 0});
    vecs.push_back('{"err_disc",      0, 0, 1, 16'h0005, 16'h9999, 3'b000, 0});
    vecs.push_back('{"cfg_ok",        1, 0, 0, 16'h0007, 16'h9999, 3'b001, 1});
    vecs.push_back('{"conn_rzero",    0, 1, 0, 16'h0007, 16'h0000, 3'b111, 0});
    vecs.push_back('{"err2_conn",     0, 1, 0, 16'h0007, 16'h0003, 3'b111, 0});
    vecs.push_back('{"err2_cfg",      1, 0, 0, 16'h0007, 16'h0003, 3'b111, 0});
    vecs.push_back('{"err2_disc",     0, 0, 1, 16'h0007, 16'h0003, 3'b000, 0});
    vecs.push_back('{"cfg_b",         1, 0, 0, 16'h0001, 16'h0002, 3'b001, 1});
    vecs.push_back('{"conn_b",        0, 1, 0, 16'h0001, 16'h0002, 3'b010, 1});
    vecs.push_back('{"prio_conn_disc",0, 1, 1, 16'h0001, 16'h0002, 3'b000, 0});
    vecs.push_back('{"prio_conn_cfg", 1, 1, 0, 16'h0003, 16'h0002, 3'b000, 0});
    vecs.push_back('{"cfg_c",         1, 0, 0, 16'h0003, 16'h0002, 3'b001, 1});
    vecs.push_back('{"init_conn_cfg", 1, 1, 0, 16'h0003, 16'h0004, 3'b010, 1});
    vecs.push_back('{"prio_cfg_disc", 1, 0, 1, 16'h0003, 16'h0004, 3'b000, 0});

    foreach (vecs[i]) begin
      cycle(vecs[i].cfg, vecs[i].conn, vecs[i].disc, vecs[i].lq, vecs[i].rq);
      expect_st(vecs[i].name, vecs[i].exp_state, vecs[i].exp_ready);
    end

    // Nominal bring-up with connect held two cycles, then idle 10 before teardown
    cycle(1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678);
    expect_st("held_cfg", 3'b001, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 16'h1234, 16'h5678);
    expect_st("held_conn_a", 3'b010, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 16'h1234, 16'h5678);
    expect_st("held_conn_b", 3'b011, 1'b1);
    idle(10);
    expect_st("rts_hold10", 3'b011, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 16'h1234, 16'h5678);
    expect_st("late_disc", 3'b000, 1'b0);

    // Asynchronous reset entered mid-cycle while in RTS
    cycle(1'b1, 1'b0, 1'b0, 16'h00aa, 16'h00bb);
    cycle(1'b0, 1'b1, 1'b0, 16'h00aa, 16'h00bb);
    cycle(1'b0, 1'b1, 1'b0, 16'h00aa, 16'h00bb);
    expect_st("pre_async", 3'b011, 1'b1);
    cfg_valid = 1'b0; cmd_connect = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    expect_st("async_mid", 3'b000, 1'b0);
    @(posedge clk);
    #1;
    expect_st("async_hold", 3'b000, 1'b0);
    rst_n = 1'b1;
    idle(2);
    expect_st("no_self_init", 3'b000, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 16'h00aa, 16'h00bb);
    expect_st("conn_after_rst", 3'b000, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 16'h00aa, 16'h00bb);
    expect_st("recfg", 3'b001, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 16'h00aa, 16'h00bb);
    expect_st("recfg_disc", 3'b000, 1'b0);

    // Randomized traffic against the reference model, with occasional async resets
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        c, n, d;
      logic [15:0] lq, rq;
      c  = ($urandom_range(0, 3) == 0);
      n  = ($urandom_range(0, 2) == 0);
      d  = ($urandom_range(0, 11) == 0);
      lq = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      rq = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        expect_st("rand_async", model_state(), model_ready());
        #1 rst_n = 1'b1;
      end
      cycle(c, n, d, lq, rq);
      model_step(c, n, d, lq, rq);
      expect_st("rand", model_state(), model_ready());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rdma_rc_qp_fsm.md
Name: rdma_rc_qp_fsm

Overview:
Connection-state controller for one RDMA Reliable-Connection queue pair. It sequences the QP through the RESET, INIT, RTR and RTS states under host configuration and connect/disconnect commands. It latches the local and remote QP numbers and flags data-path readiness. It sits between the host control plane and the RC transport engine, which may only issue traffic while the QP is in RTS.

Parameters:
QPN_WIDTH, 16, width of local and remote QP numbers.

Ports:
clk  input  1  sole clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
local_qpn  input  QPN_WIDTH  local QP number; sampled on cfg_valid.
remote_qpn  input  QPN_WIDTH  remote QP number; sampled on the first cmd_connect in INIT.
cfg_valid  input  1  one-cycle pulse: apply QP configuration.
cmd_connect  input  1  one-cycle pulse: advance the connection (INIT->RTR, RTR->RTS).
cmd_disconnect  input  1  one-cycle pulse: tear the QP down to RESET.
qp_state  output  3  current state encoding.
qp_ready  output  1  QP configured and usable.

Behaviour:
- State encodings:
  - RESET = 3'b000
  - INIT = 3'b001
  - RTR = 3'b010
  - RTS = 3'b011
  - ERROR = 3'b111
  - 3'b100, 3'b101 and 3'b110 are illegal.
- Reset (asynchronous, rst_n low): qp_state = RESET, qp_ready = 0, latched local QPN = 0, latched remote QPN = 0.
  - Holds for as long as rst_n is low.
  - Reset mid-operation from any state returns to RESET immediately and discards the latched QPNs.
- qp_state is a register. qp_ready is a combinational decode of that register:
  - 1 in INIT, RTR and RTS.
  - 0 in RESET and ERROR.
- Latency: a command sampled high on rising edge N updates qp_state (and qp_ready) immediately after edge N. The new value is visible at edge N+1.
- Priority per cycle, highest first: cmd_disconnect, then cmd_connect, then cfg_valid. Lower-priority inputs asserted in the same cycle are ignored.
- Transitions:
  - RESET + cfg_valid, local_qpn != 0 -> INIT; latch local_qpn.
  - RESET + cfg_valid, local_qpn == 0 -> ERROR.
  - RESET + cmd_connect -> ignored; stay in RESET.
  - INIT + cmd_connect, remote_qpn != 0 -> RTR; latch remote_qpn.
  - INIT + cmd_connect, remote_qpn == 0 -> ERROR.
  - RTR + cmd_connect -> RTS.
  - RTS + cmd_connect -> ignored; stay in RTS.
  - cfg_valid in any state other than RESET -> ignored.
  - Any state + cmd_disconnect -> RESET; clear both latched QPNs. This is also the only exit from ERROR.
  - Illegal encoding -> ERROR on the next edge.
  - No input asserted -> hold the current state.
- Input QPN changes after latching have no effect on the state or on the latched values.
- Back-to-back pulses are each honoured in order, one transition per cycle. Example: cmd_connect held for 2 cycles in INIT gives INIT -> RTR -> RTS.
- All outputs are defined (no X) from the first clock after reset release.

Test Plan:
- Reset hold: rst_n = 0 for 2 cycles -> qp_state = 3'b000 and qp_ready = 0 at every rising edge; async entry checked mid-cycle.
- Nominal bring-up:
  - local_qpn = 16'h1234, then a cfg_valid pulse -> INIT, qp_ready = 1.
  - remote_qpn = 16'h5678, then a cmd_connect pulse -> RTR.
  - A second cmd_connect pulse -> RTS, qp_ready = 1.
  - cmd_disconnect after 10 cycles -> RESET, qp_ready = 0.
- Error paths:
  - cfg_valid with local_qpn = 0 -> ERROR (3'b111), qp_ready = 0.
  - cmd_connect in INIT with remote_qpn = 0 -> ERROR.
  - In both cases, cmd_connect and cfg_valid are then ignored; cmd_disconnect -> RESET.
- Ignored commands:
  - cmd_connect in RESET -> stays RESET.
  - cfg_valid in RTS -> stays RTS.
  - Changing remote_qpn to 16'h9999 in RTS -> stays RTS.
- Priority: in RTR, assert cmd_connect and cmd_disconnect in the same cycle -> RESET, not RTS.
- Reset mid-operation: assert rst_n low while in RTS -> RESET immediately. A new cfg_valid is then required to reach INIT.
